adder: RTL and testbench

//  - Registered unsigned ripple-carry adder; the datapath primitive of the SimpleALU.
//  - Adds two WIDTH-bit operands and registers the WIDTH-bit sum plus carry-out.
//  - Used by the ALU for ADD and as the base for the increment/compare paths.
//  - A valid flag travels alongside the data so upstream and downstream logic can pipeline through it.

---
 rtl/adder_pkg.sv | 17 +
 rtl/adder_full_adder.sv | 17 +
 rtl/adder.sv | 49 ++++
 tb/tb_adder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared width default, operand type and a golden add helper.
// Imported by the adder top and by benches.
package adder_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 8;

    typedef logic [ADDER_WIDTH_DEFAULT-1:0] operand_t;

    // Reference {carry,sum} at full precision, for benches.
    function automatic logic [ADDER_WIDTH_DEFAULT:0] golden_add(
        input operand_t a,
        input operand_t b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/adder_full_adder.sv
// full_adder: one-bit full adder cell of the ripple chain.
// Ports: a, b, cin in; s (sum bit), cout (carry to next bit) out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/adder.sv
// adder: registered unsigned ripple-carry adder with a valid flag.
// Ports: clk_i, rst_ni, valid_i, a_i, b_i in; valid_o, sum, carry out.
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    // No carry-in: chain starts at zero.
    assign c[0] = 1'b0;

    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        full_adder u_fa (
            .a    (a_i[k]),
            .b    (b_i[k]),
            .cin  (c[k]),
            .s    (s[k]),
            .cout (c[k+1])
        );
    end

    // Result registers load only on valid, so idle operands never reach them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum     <= '0;
            carry   <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                sum   <= s;
                carry <= c[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_adder.sv
// tb_adder: randomized and directed checks of adder at WIDTH=8 and WIDTH=4
// against an arithmetic model of the registered sum/carry/valid.
module tb_adder;

    logic       clk;
    logic       rst_n;
    logic       valid;
    logic [7:0] a;
    logic [7:0] b;
    logic       valid_o;
    logic [7:0] sum;
    logic       carry;

    logic       v4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       valid4_o;
    logic [3:0] sum4;
    logic       carry4;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 0;

    adder #(.WIDTH(8)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid),
        .a_i     (a),
        .b_i     (b),
        .valid_o (valid_o),
        .sum     (sum),
        .carry   (carry)
    );

    adder #(.WIDTH(4)) dut4 (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (v4),
        .a_i     (a4),
        .b_i     (b4),
        .valid_o (valid4_o),
        .sum     (sum4),
        .carry   (carry4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: last valid total kept as an integer, split at 2^W.
    int   m_tot  = 0;
    logic m_val  = 1'b0;
    int   m_tot4 = 0;
    logic m_val4 = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tot  <= 0;
            m_val  <= 1'b0;
            m_tot4 <= 0;
            m_val4 <= 1'b0;
        end else begin
            m_val  <= valid;
            m_val4 <= v4;
            if (valid) m_tot <= int'(a) + int'(b);
            if (v4) m_tot4 <= int'(a4) + int'(b4);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("sum8", 32'(sum), m_tot % 256);
            chk("carry8", 32'(carry), 32'(m_tot >= 256));
            chk("valid8", 32'(valid_o), 32'(m_val));
            chk("sum4", 32'(sum4), m_tot4 % 16);
            chk("carry4", 32'(carry4), 32'(m_tot4 >= 16));
            chk("valid4", 32'(valid4_o), 32'(m_val4));
        end
    end

    task automatic lit(input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] es, input logic ec);
        @(negedge clk);
        a     = x;
        b     = y;
        valid = 1'b1;
        @(posedge clk);
        #1;
        chk("lit_sum", 32'(sum), 32'(es));
        chk("lit_carry", 32'(carry), 32'(ec));
        chk("lit_valid", 32'(valid_o), 32'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        valid = 1'b0;
        a     = '0;
        b     = '0;
        v4    = 1'b0;
        a4    = '0;
        b4    = '0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry", 32'(carry), 32'd0);
        chk("rst_valid", 32'(valid_o), 32'd0);
        armed = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        lit(8'h95, 8'hD2, 8'h67, 1'b1);
        lit(8'h00, 8'h00, 8'h00, 1'b0);
        lit(8'h7F, 8'h01, 8'h80, 1'b0);
        lit(8'hFF, 8'h01, 8'h00, 1'b1);
        lit(8'hFF, 8'hFF, 8'hFE, 1'b1);

        @(negedge clk);
        valid = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        @(posedge clk);
        #1;
        chk("hold_sum", 32'(sum), 32'hFE);
        chk("hold_carry", 32'(carry), 32'd1);
        chk("hold_valid", 32'(valid_o), 32'd0);

        @(negedge clk);
        v4 = 1'b1;
        a4 = 4'hF;
        b4 = 4'h1;
        @(posedge clk);
        #1;
        chk("w4_sum", 32'(sum4), 32'h0);
        chk("w4_carry", 32'(carry4), 32'd1);
        chk("w4_valid", 32'(valid4_o), 32'd1);

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 3) != 0);
            a     = 8'($urandom);
            b     = 8'($urandom);
            v4    = ($urandom_range(0, 3) != 0);
            a4    = 4'($urandom);
            b4    = 4'($urandom);
            if (i == 5000) begin
                #2 rst_n = 1'b0;
                #1;
                chk("mid_rst_sum", 32'(sum), 32'd0);
                chk("mid_rst_carry", 32'(carry), 32'd0);
                chk("mid_rst_valid", 32'(valid_o), 32'd0);
                chk("mid_rst_sum4", 32'(sum4), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        valid = 1'b0;
        v4    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
